// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 7/8 data bits, none/even/odd parity, 1/2 stop bits.
// Bit timing is driven by an external oversampling tick (OVS ticks per bit).
module uart_tx_cfg #(
    parameter int OVS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    input  logic       d_num,
    input  logic       s_num,
    input  logic [1:0] par,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam int CW = $clog2(2 * OVS);
    localparam logic [CW-1:0] BIT_LAST   = CW'(OVS - 1);
    localparam logic [CW-1:0] STOP2_LAST = CW'(2 * OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] tick_cnt, tick_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [7:0]    shift_reg, shift_nx;
    logic          d8_r, s2_r, par_en_r, par_bit_r;
    logic          tx_nx;
    logic          bit_end, stop_end, accept;

    assign accept   = (state == IDLE) && tx_start;
    assign bit_end  = s_tick && (tick_cnt == BIT_LAST);
    assign stop_end = s_tick && (tick_cnt == (s2_r ? STOP2_LAST : BIT_LAST));

    // State, counters, shadow config and the registered line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            d8_r      <= 1'b0;
            s2_r      <= 1'b0;
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_nx;
            tick_cnt  <= tick_nx;
            bit_cnt   <= bit_nx;
            shift_reg <= shift_nx;
            tx        <= tx_nx;
            if (accept) begin
                d8_r      <= d_num;
                s2_r      <= s_num;
                par_en_r  <= (par == 2'b01) || (par == 2'b10);
                par_bit_r <= (^(din & {d_num, 7'h7f})) ^ (par == 2'b10);
            end
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick_cnt;
        bit_nx   = bit_cnt;
        shift_nx = shift_reg;
        if (state != IDLE && s_tick)
            tick_nx = tick_cnt + CW'(1);
        unique case (state)
            IDLE: begin
                if (tx_start) begin
                    state_nx = START;
                    tick_nx  = '0;
                    bit_nx   = '0;
                    shift_nx = din;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx = DATA;
                    tick_nx  = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_nx  = '0;
                    shift_nx = shift_reg >> 1;
                    bit_nx   = bit_cnt + 3'd1;
                    // last data bit index is 6 or 7
                    if (bit_cnt == {2'b11, d8_r})
                        state_nx = par_en_r ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nx = STOP;
                    tick_nx  = '0;
                end
            end
            STOP: begin
                if (stop_end) begin
                    state_nx = IDLE;
                    tick_nx  = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Line value is chosen from the upcoming state so tx changes with it
    always_comb begin
        tx_busy      = (state != IDLE);
        tx_done_tick = (state == STOP) && stop_end;
        tx_nx        = 1'b1;
        unique case (state_nx)
            IDLE:    tx_nx = 1'b1;
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            PARITY:  tx_nx = par_bit_r;
            STOP:    tx_nx = 1'b1;
            default: tx_nx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: random/directed frames checked cycle by cycle
// against a bit-list model of the serial frame.
module tb_uart_tx_cfg;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       d_num = 1'b1;
    logic       s_num = 1'b0;
    logic [1:0] par = 2'b00;
    logic       tx_busy, tx_done_tick, tx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tick_per = 1;

    bit   m_busy = 0;
    bit   m_bits[$];
    int   m_n = 0;
    int   acc_cyc = 0;
    int   done_clk = 0;
    int   done_cyc = 0;
    int   rise_cyc = 0;
    int   accepts = 0;
    logic prev_busy = 1'b0;

    uart_tx_cfg #(.OVS(OVS)) dut (
        .clk(clk),
        .reset(reset),
        .s_tick(s_tick),
        .tx_start(tx_start),
        .din(din),
        .d_num(d_num),
        .s_num(s_num),
        .par(par),
        .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick),
        .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Frame as a list of line levels, one entry per OVS ticks
    function automatic void build(input logic [7:0] b, input logic d8,
                                  input logic s2, input logic [1:0] p);
        int nd;
        int ones;
        nd = d8 ? 8 : 7;
        ones = 0;
        m_bits.delete();
        m_bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            m_bits.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (p == 2'b01 || p == 2'b10)
            m_bits.push_back(((ones % 2) == 1) ^ (p == 2'b10));
        m_bits.push_back(1'b1);
        if (s2)
            m_bits.push_back(1'b1);
    endfunction

    // Called at a negedge with inputs set; checks, then advances one clk
    task automatic tick_cycle();
        logic etx;
        logic edone;
        int   total;
        if (tick_per == 0)
            s_tick = ($urandom_range(2) == 0);
        else
            s_tick = ((cyc % tick_per) == 0);
        #1;
        total = m_bits.size() * OVS;
        etx   = m_busy ? m_bits[m_n / OVS] : 1'b1;
        edone = m_busy && s_tick && (m_n == total - 1);
        chk("tx", tx, etx);
        chk("busy", tx_busy, m_busy);
        chk("done", tx_done_tick, edone);
        if (tx_done_tick === 1'b1) begin
            done_clk = cyc - acc_cyc + 1;
            done_cyc = cyc;
        end
        if (tx_busy === 1'b1 && prev_busy === 1'b0)
            rise_cyc = cyc;
        prev_busy = tx_busy;
        @(posedge clk);
        cyc++;
        if (m_busy) begin
            if (s_tick) begin
                m_n++;
                if (m_n == total)
                    m_busy = 0;
            end
        end else if (tx_start) begin
            build(din, d_num, s_num, par);
            m_n = 0;
            m_busy = 1;
            acc_cyc = cyc;
            accepts++;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic d8, input logic s2,
                        input logic [1:0] p, input int per, input int exp_clk,
                        input bit churn);
        int guard;
        tick_per = per;
        din = b;
        d_num = d8;
        s_num = s2;
        par = p;
        done_clk = 0;
        tx_start = 1'b1;
        tick_cycle();
        tx_start = 1'b0;
        guard = 0;
        while (m_busy && guard < 5000) begin
            if (churn) begin
                din = 8'($urandom);
                d_num = 1'($urandom_range(1));
                s_num = 1'($urandom_range(1));
                par = 2'($urandom_range(3));
                tx_start = ($urandom_range(7) == 0) &&
                           (m_n < int'(m_bits.size()) * OVS - 2);
            end
            tick_cycle();
            guard++;
        end
        tx_start = 1'b0;
        chk("frame_timeout", 32'(guard < 5000), 1);
        if (exp_clk > 0)
            chk("done_clk", done_clk, exp_clk);
        repeat (2) tick_cycle();
    endtask

    task automatic back_to_back();
        int guard;
        int acc0;
        int d1;
        tick_per = 1;
        din = 8'hA5;
        d_num = 1'b1;
        s_num = 1'b0;
        par = 2'b00;
        tx_start = 1'b1;
        acc0 = accepts;
        d1 = -1;
        guard = 0;
        while (!(accepts == acc0 + 2 && !m_busy) && guard < 2000) begin
            if (accepts == acc0 + 1 && m_busy)
                din = 8'h3C;
            tick_cycle();
            if (accepts == acc0 + 1 && !m_busy && d1 < 0)
                d1 = done_cyc;
            guard++;
        end
        tx_start = 1'b0;
        chk("b2b_timeout", 32'(guard < 2000), 1);
        chk("b2b_gap", rise_cyc - d1, 2);
        repeat (2) tick_cycle();
    endtask

    task automatic reset_mid_frame();
        int guard;
        tick_per = 1;
        din = 8'hF0;
        d_num = 1'b1;
        s_num = 1'b0;
        par = 2'b00;
        tx_start = 1'b1;
        tick_cycle();
        tx_start = 1'b0;
        guard = 0;
        while (m_n < 4 * OVS + 5 && guard < 1000) begin
            tick_cycle();
            guard++;
        end
        reset = 1'b1;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done_tick, 0);
        m_busy = 0;
        prev_busy = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick_cycle();
        send(8'hB2, 1'b1, 1'b0, 2'b00, 1, 10 * OVS, 0);
    endtask

    initial begin
        int per;
        int nbits;
        logic [7:0] b;
        logic d8, s2;
        logic [1:0] p;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_done", tx_done_tick, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick_cycle();

        send(8'h55, 1'b1, 1'b0, 2'b00, 1, 160, 0);
        send(8'h55, 1'b1, 1'b0, 2'b01, 1, 176, 0);
        send(8'h55, 1'b1, 1'b0, 2'b10, 1, 176, 0);
        send(8'h07, 1'b1, 1'b0, 2'b01, 1, 176, 0);
        send(8'hC1, 1'b0, 1'b1, 2'b01, 1, 176, 0);
        send(8'h55, 1'b1, 1'b0, 2'b00, 4, 0, 1);
        send(8'h96, 1'b1, 1'b0, 2'b00, 4, 0, 1);
        back_to_back();
        reset_mid_frame();

        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            d8 = 1'($urandom_range(1));
            s2 = 1'($urandom_range(1));
            p = 2'($urandom_range(3));
            per = $urandom_range(3);
            nbits = 1 + (d8 ? 8 : 7) + ((p == 2'b01 || p == 2'b10) ? 1 : 0)
                    + (s2 ? 2 : 1);
            send(b, d8, s2, p, per, (per == 1) ? nbits * OVS : 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
